// File: rtl/spi_pkg.sv
// spi_pkg
//   Shared definitions for the SPI target port: FSM state encoding, the
//   width of the frame-length field and a helper that maps a requested
//   frame length onto a legal one.
//   No ports (package).
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_t;

  // Width of num_bits and of the internal length / bit counters.
  localparam int LEN_W = 5;

  // Frame length held in the length register out of reset.
  localparam logic [LEN_W-1:0] DEFAULT_LEN = 5'd16;

  // A zero or over-long request means "use the full data width".
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] requested,
                                                 input logic [LEN_W-1:0] max_len);
    return ((requested == '0) || (requested > max_len)) ? max_len : requested;
  endfunction

endpackage

// File: rtl/spi_slave_port_if.sv
// spi_slave_port_if
//   Valid/ready streams between the SPI target port and the register
//   wrapper: a TX word going out on SDO and an RX word assembled from SDI.
//   master modport : register wrapper side (produces TX, consumes RX)
//   slave modport  : SPI target port side
interface spi_slave_port_if #(
  parameter int DATA_WIDTH = 24
);

  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid
  );

endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge
//   Synchroniser for one asynchronous SPI pin plus registered edge pulses.
//   S_AXI_ACLK     in  clock
//   S_AXI_ARESETN  in  asynchronous active-low reset
//   pin            in  raw pin level
//   level          out synchronised level
//   rise / fall    out one-cycle pulses, one clock after the synchronised edge
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic S_AXI_ACLK,
  input  logic S_AXI_ARESETN,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [SYNC_STAGES:0]   primed_q;

  // Edge pulses stay masked until the chain and the previous-level flop
  // hold real pin samples, so a pin already away from its idle level at
  // reset release never looks like a fresh edge.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      sync_q   <= {SYNC_STAGES{RESET_VAL}};
      prev_q   <= RESET_VAL;
      primed_q <= '0;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], pin};
      prev_q   <= sync_q[SYNC_STAGES-1];
      primed_q <= {primed_q[SYNC_STAGES-1:0], 1'b1};
      rise     <= primed_q[SYNC_STAGES] &  sync_q[SYNC_STAGES-1] & ~prev_q;
      fall     <= primed_q[SYNC_STAGES] & ~sync_q[SYNC_STAGES-1] &  prev_q;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_port.sv
// spi_slave_port
//   SPI mode-0 target, MSB first, 1..DATA_WIDTH-bit frames. Deserialises
//   SDI into an RX stream word and serialises the queued TX word on SDO.
//   S_AXI_ACLK, S_AXI_ARESETN  clock, asynchronous active-low reset
//   SCK, SDI, CS_              pins from the external master (asynchronous)
//   SDO, SDO_EN                target data out and its pad enable
//   num_bits                   frame length sampled at the start of a frame
//   stream                     TX/RX valid-ready streams (slave modport)
//   tx_underrun, rx_overflow   sticky status, cleared by clr_status
//   frame_abort                one-cycle pulse when CS_ ends a short frame
module spi_slave_port
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic             S_AXI_ACLK,
  input  logic             S_AXI_ARESETN,
  input  logic             SCK,
  input  logic             SDI,
  input  logic             CS_,
  output logic             SDO,
  output logic             SDO_EN,
  input  logic [LEN_W-1:0] num_bits,
  input  logic             clr_status,
  output logic             tx_underrun,
  output logic             rx_overflow,
  output logic             frame_abort,
  spi_slave_port_if.slave  stream
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_WIDTH);

  logic sck_level, sck_rise, sck_fall;
  logic sdi_level, sdi_rise, sdi_fall;
  logic cs_level, cs_rise, cs_fall;

  spi_state_t state_q, state_d;
  logic start_frame, finish_frame, abort_frame;

  logic [LEN_W-1:0]      len_q, bit_cnt_q, len_start;
  logic [DATA_WIDTH-1:0] shift_in_q, shift_out_q;
  logic [DATA_WIDTH-1:0] tx_hold_q, tx_src, tx_aligned;
  logic                  tx_full_q;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  rx_valid_q;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck (
    .S_AXI_ACLK(S_AXI_ACLK), .S_AXI_ARESETN(S_AXI_ARESETN), .pin(SCK),
    .level(sck_level), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sdi (
    .S_AXI_ACLK(S_AXI_ACLK), .S_AXI_ARESETN(S_AXI_ARESETN), .pin(SDI),
    .level(sdi_level), .rise(sdi_rise), .fall(sdi_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs (
    .S_AXI_ACLK(S_AXI_ACLK), .S_AXI_ARESETN(S_AXI_ARESETN), .pin(CS_),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  wire unused_sync = &{1'b0, sck_level, sdi_rise, sdi_fall, cs_level};

  // State register.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) state_q <= IDLE;
    else                state_q <= state_d;
  end

  // Frame sequencing. Completion is recognised on the SCK rise that
  // samples the last bit; it wins over a CS_ rise in the same cycle.
  always_comb begin
    state_d      = state_q;
    start_frame  = 1'b0;
    finish_frame = 1'b0;
    abort_frame  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          start_frame = 1'b1;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (sck_rise && ((bit_cnt_q + LEN_W'(1)) == len_q)) begin
          finish_frame = 1'b1;
          state_d      = IDLE;
        end else if (cs_rise) begin
          abort_frame = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The TX word is left-aligned in the shift register so SDO always comes
  // from the top bit whatever the frame length.
  always_comb begin
    len_start  = clamp_len(num_bits, MAX_LEN);
    tx_src     = tx_full_q ? tx_hold_q : '0;
    tx_aligned = tx_src << (MAX_LEN - len_start);
  end

  // Shift registers, bit counter and SDO.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      len_q       <= DEFAULT_LEN;
      bit_cnt_q   <= '0;
      shift_in_q  <= '0;
      shift_out_q <= '0;
      SDO         <= 1'b0;
    end else if (start_frame) begin
      len_q       <= len_start;
      bit_cnt_q   <= '0;
      shift_in_q  <= '0;
      shift_out_q <= tx_aligned;
      SDO         <= tx_aligned[DATA_WIDTH-1];
    end else if (state_q == SHIFT) begin
      if (sck_rise) begin
        shift_in_q <= {shift_in_q[DATA_WIDTH-2:0], sdi_level};
        bit_cnt_q  <= bit_cnt_q + LEN_W'(1);
      end
      if (sck_fall) begin
        shift_out_q <= shift_out_q << 1;
        SDO         <= shift_out_q[DATA_WIDTH-2];
      end
      if (finish_frame || abort_frame) SDO <= 1'b0;
    end
  end

  // TX holding register. A word offered while the frame start empties an
  // already-empty register is kept for the following frame.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      tx_hold_q <= '0;
      tx_full_q <= 1'b0;
    end else if (start_frame && tx_full_q) begin
      tx_full_q <= 1'b0;
    end else if (stream.tx_valid && !tx_full_q) begin
      tx_hold_q <= stream.tx_data;
      tx_full_q <= 1'b1;
    end
  end

  // RX output register and status flags. The newest frame always replaces
  // the RX word; clr_status beats a same-cycle flag set.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_underrun <= 1'b0;
      rx_overflow <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      if (finish_frame) begin
        rx_data_q  <= {shift_in_q[DATA_WIDTH-2:0], sdi_level};
        rx_valid_q <= 1'b1;
      end else if (stream.rx_ready) begin
        rx_valid_q <= 1'b0;
      end
      if (clr_status)                                       tx_underrun <= 1'b0;
      else if (start_frame && !tx_full_q)                   tx_underrun <= 1'b1;
      if (clr_status)                                       rx_overflow <= 1'b0;
      else if (finish_frame && rx_valid_q && !stream.rx_ready) rx_overflow <= 1'b1;
      frame_abort <= abort_frame;
    end
  end

  assign SDO_EN          = (state_q == SHIFT);
  assign stream.tx_ready = ~tx_full_q;
  assign stream.rx_data  = rx_data_q;
  assign stream.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_port.sv
// tb_spi_slave_port
//   Self-checking bench: reset values, a table of fixed frames, hand-written
//   corner sequences and randomised frames against a frame-level model.
module tb_spi_slave_port;

  localparam int DW = 24;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sck = 1'b0;
  logic       sdi = 1'b0;
  logic       cs_n = 1'b1;
  logic       clr_status = 1'b0;
  logic [4:0] num_bits = 5'd16;
  wire        sdo, sdo_en, tx_underrun, rx_overflow, frame_abort;

  spi_slave_port_if #(.DATA_WIDTH(DW)) stream_bus ();

  spi_slave_port #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .SCK(sck), .SDI(sdi), .CS_(cs_n),
    .SDO(sdo), .SDO_EN(sdo_en),
    .num_bits(num_bits), .clr_status(clr_status),
    .tx_underrun(tx_underrun), .rx_overflow(rx_overflow), .frame_abort(frame_abort),
    .stream(stream_bus)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int abort_pulses = 0;
  int rxv_rises = 0;
  int rxv_rise_cyc = 0;
  logic rxv_prev = 1'b0;
  int last_rise_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor pulses and rx_valid rising edges away from the active edge.
  always @(negedge clk) begin
    if (frame_abort === 1'b1) abort_pulses <= abort_pulses + 1;
    if (stream_bus.rx_valid === 1'b1 && rxv_prev == 1'b0) begin
      rxv_rises    <= rxv_rises + 1;
      rxv_rise_cyc <= cyc;
    end
    rxv_prev <= stream_bus.rx_valid;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Frame-level reference model state.
  logic        m_full, m_rxv, m_und, m_ovf;
  logic [23:0] m_hold, m_rx;

  task automatic checkOutput(input string name, input logic [23:0] act, input logic [23:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int effLen(input logic [4:0] nb);
    return (nb == 5'd0 || nb > 5'd24) ? 24 : int'(nb);
  endfunction

  function automatic logic [23:0] lenMask(input int len);
    return (len >= 24) ? 24'hFFFFFF : 24'((32'd1 << len) - 32'd1);
  endfunction

  task automatic shiftBits(input int n, input logic [23:0] mosi,
                           output logic [23:0] miso, output bit en_ok);
    miso  = '0;
    en_ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      sdi = mosi[5'(n - 1 - i)];
      tick(3);
      sck = 1'b1;
      last_rise_cyc = cyc;
      tick(3);
      miso = {miso[22:0], sdo};
      if (sdo_en !== 1'b1) en_ok = 1'b0;
      sck = 1'b0;
    end
    sdi = 1'b0;
  endtask

  task automatic queueTx(input logic [23:0] w);
    stream_bus.tx_data  = w;
    stream_bus.tx_valid = 1'b1;
    tick(1);
    stream_bus.tx_valid = 1'b0;
  endtask

  task automatic popRx();
    stream_bus.rx_ready = 1'b1;
    tick(1);
    stream_bus.rx_ready = 1'b0;
  endtask

  task automatic clrStatus();
    clr_status = 1'b1;
    tick(1);
    clr_status = 1'b0;
  endtask

  // Full frame; optionally offers a TX word in the cycle the port sees CS_ fall.
  task automatic applyStimulus(input logic [4:0] nb, input logic [23:0] mosi,
                               input bit inject, input logic [23:0] inj_word,
                               output logic [23:0] miso, output bit en_ok);
    num_bits = nb;
    cs_n = 1'b0;
    tick(3);
    if (inject) begin
      stream_bus.tx_data  = inj_word;
      stream_bus.tx_valid = 1'b1;
      tick(1);
      stream_bus.tx_valid = 1'b0;
      tick(2);
    end else begin
      tick(3);
    end
    shiftBits(effLen(nb), mosi, miso, en_ok);
    tick(3);
    cs_n = 1'b1;
    tick(6);
  endtask

  typedef struct {
    logic [4:0]  nb;
    bit          queue_tx;
    logic [23:0] tx_word;
    logic [23:0] mosi;
    logic [23:0] exp_miso;
    logic [23:0] exp_rx;
    logic        exp_und;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [23:0] miso, w, mosi, exp_miso;
    logic [4:0]  nb;
    bit          en_ok, accepted;
    int          snap, len;

    stream_bus.tx_data  = '0;
    stream_bus.tx_valid = 1'b0;
    stream_bus.rx_ready = 1'b0;

    vecs[0] = '{5'd16, 1'b1, 24'h00A5C3, 24'h001234, 24'h00A5C3, 24'h001234, 1'b0};
    vecs[1] = '{5'd24, 1'b1, 24'hFFFFFF, 24'h5A5A5A, 24'hFFFFFF, 24'h5A5A5A, 1'b0};
    vecs[2] = '{5'd0,  1'b1, 24'hFFFFFF, 24'h123456, 24'hFFFFFF, 24'h123456, 1'b0};
    vecs[3] = '{5'd16, 1'b0, 24'h000000, 24'h0000FF, 24'h000000, 24'h0000FF, 1'b1};
    vecs[4] = '{5'd8,  1'b1, 24'hABCDC3, 24'h00007E, 24'h0000C3, 24'h00007E, 1'b0};
    vecs[5] = '{5'd31, 1'b1, 24'h800001, 24'h000001, 24'h800001, 24'h000001, 1'b0};
    vecs[6] = '{5'd4,  1'b1, 24'h000009, 24'h000006, 24'h000009, 24'h000006, 1'b0};

    // Reset values.
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick(3);
    checkOutput("reset_sdo", 24'(sdo), 24'h0);
    checkOutput("reset_sdo_en", 24'(sdo_en), 24'h0);
    checkOutput("reset_tx_ready", 24'(stream_bus.tx_ready), 24'h1);
    checkOutput("reset_rx_valid", 24'(stream_bus.rx_valid), 24'h0);
    checkOutput("reset_rx_data", stream_bus.rx_data, 24'h0);
    checkOutput("reset_underrun", 24'(tx_underrun), 24'h0);
    checkOutput("reset_overflow", 24'(rx_overflow), 24'h0);
    checkOutput("reset_abort", 24'(frame_abort), 24'h0);
    rst_n = 1'b1;
    tick(8);

    // Table of fixed frames.
    for (int v = 0; v < 7; v++) begin
      popRx();
      clrStatus();
      if (vecs[v].queue_tx) begin
        queueTx(vecs[v].tx_word);
        checkOutput("vec_tx_ready_full", 24'(stream_bus.tx_ready), 24'h0);
      end
      applyStimulus(vecs[v].nb, vecs[v].mosi, 1'b0, 24'h0, miso, en_ok);
      checkOutput($sformatf("vec%0d_miso", v), miso, vecs[v].exp_miso);
      checkOutput($sformatf("vec%0d_rx_data", v), stream_bus.rx_data, vecs[v].exp_rx);
      checkOutput($sformatf("vec%0d_rx_valid", v), 24'(stream_bus.rx_valid), 24'h1);
      checkOutput($sformatf("vec%0d_tx_ready", v), 24'(stream_bus.tx_ready), 24'h1);
      checkOutput($sformatf("vec%0d_underrun", v), 24'(tx_underrun), 24'(vecs[v].exp_und));
      checkOutput($sformatf("vec%0d_sdo_en", v), 24'(en_ok), 24'h1);
    end

    // Single rx_valid per frame, latency from last SCK rise, held until ready.
    popRx();
    clrStatus();
    queueTx(24'h00A5C3);
    snap = rxv_rises;
    applyStimulus(5'd16, 24'h001234, 1'b0, 24'h0, miso, en_ok);
    checkOutput("h1_miso", miso, 24'h00A5C3);
    checkOutput("h1_rx_valid_rises", 24'(rxv_rises - snap), 24'h1);
    checkOutput("h1_rx_latency", 24'(rxv_rise_cyc - last_rise_cyc), 24'h4);
    tick(5);
    checkOutput("h1_rx_valid_held", 24'(stream_bus.rx_valid), 24'h1);
    popRx();
    checkOutput("h1_rx_valid_cleared", 24'(stream_bus.rx_valid), 24'h0);

    // Underrun is sticky until clr_status.
    applyStimulus(5'd16, 24'h0000FF, 1'b0, 24'h0, miso, en_ok);
    checkOutput("h3_miso_zero", miso, 24'h0);
    checkOutput("h3_underrun_set", 24'(tx_underrun), 24'h1);
    clrStatus();
    checkOutput("h3_underrun_clr", 24'(tx_underrun), 24'h0);

    // Two frames without consuming: overflow, newest wins.
    popRx();
    clrStatus();
    applyStimulus(5'd16, 24'h000001, 1'b0, 24'h0, miso, en_ok);
    checkOutput("h4_no_ovf_first", 24'(rx_overflow), 24'h0);
    applyStimulus(5'd16, 24'h000002, 1'b0, 24'h0, miso, en_ok);
    checkOutput("h4_rx_data", stream_bus.rx_data, 24'h000002);
    checkOutput("h4_overflow", 24'(rx_overflow), 24'h1);
    checkOutput("h4_rx_valid", 24'(stream_bus.rx_valid), 24'h1);

    // rx_ready in the completion cycle: old word accepted, no overflow.
    clrStatus();
    num_bits = 5'd16;
    cs_n = 1'b0;
    tick(6);
    shiftBits(15, 24'h00ACE1 >> 1, miso, en_ok);
    sdi = 1'b1;
    tick(3);
    sck = 1'b1;
    tick(3);
    stream_bus.rx_ready = 1'b1;
    tick(1);
    stream_bus.rx_ready = 1'b0;
    tick(2);
    sck = 1'b0;
    sdi = 1'b0;
    tick(3);
    cs_n = 1'b1;
    tick(6);
    checkOutput("hs_no_overflow", 24'(rx_overflow), 24'h0);
    checkOutput("hs_rx_valid", 24'(stream_bus.rx_valid), 24'h1);
    checkOutput("hs_rx_data", stream_bus.rx_data, 24'h00ACE1);

    // Abort after 7 of 16 bits, then an intact frame.
    popRx();
    clrStatus();
    num_bits = 5'd16;
    snap = abort_pulses;
    cs_n = 1'b0;
    tick(6);
    shiftBits(7, 24'h00005B, miso, en_ok);
    tick(3);
    cs_n = 1'b1;
    tick(6);
    checkOutput("h5_abort_pulses", 24'(abort_pulses - snap), 24'h1);
    checkOutput("h5_rx_valid", 24'(stream_bus.rx_valid), 24'h0);
    checkOutput("h5_sdo_en_idle", 24'(sdo_en), 24'h0);
    applyStimulus(5'd16, 24'h00BEEF, 1'b0, 24'h0, miso, en_ok);
    checkOutput("h5_next_rx", stream_bus.rx_data, 24'h00BEEF);
    checkOutput("h5_next_valid", 24'(stream_bus.rx_valid), 24'h1);

    // TX offered in the start cycle with an empty register: kept for next frame.
    popRx();
    clrStatus();
    applyStimulus(5'd16, 24'h000F0F, 1'b1, 24'h003C3C, miso, en_ok);
    checkOutput("hi_miso_zero", miso, 24'h0);
    checkOutput("hi_underrun", 24'(tx_underrun), 24'h1);
    checkOutput("hi_tx_ready_full", 24'(stream_bus.tx_ready), 24'h0);
    clrStatus();
    applyStimulus(5'd16, 24'h000F0F, 1'b0, 24'h0, miso, en_ok);
    checkOutput("hi_next_miso", miso, 24'h003C3C);
    checkOutput("hi_next_underrun", 24'(tx_underrun), 24'h0);

    // Reset mid-frame with CS_ held low.
    popRx();
    clrStatus();
    queueTx(24'h005555);
    num_bits = 5'd16;
    cs_n = 1'b0;
    tick(6);
    shiftBits(5, 24'h000013, miso, en_ok);
    rst_n = 1'b0;
    #1;
    checkOutput("h6_sdo", 24'(sdo), 24'h0);
    checkOutput("h6_sdo_en", 24'(sdo_en), 24'h0);
    checkOutput("h6_tx_ready", 24'(stream_bus.tx_ready), 24'h1);
    checkOutput("h6_rx_valid", 24'(stream_bus.rx_valid), 24'h0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    shiftBits(16, 24'h001234, miso, en_ok);
    tick(6);
    checkOutput("h6_no_rx_valid", 24'(stream_bus.rx_valid), 24'h0);
    checkOutput("h6_no_sdo_en", 24'(en_ok), 24'h0);
    cs_n = 1'b1;
    tick(6);
    applyStimulus(5'd16, 24'h00BEEF, 1'b0, 24'h0, miso, en_ok);
    checkOutput("h6_fresh_rx", stream_bus.rx_data, 24'h00BEEF);
    checkOutput("h6_fresh_miso", miso, 24'h0);

    // Randomised frames against the frame-level model.
    popRx();
    clrStatus();
    m_full = 1'b0; m_hold = '0; m_rxv = 1'b0; m_rx = 24'h00BEEF; m_und = 1'b0; m_ovf = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) != 0) begin
        w = 24'($urandom);
        accepted = !m_full;
        queueTx(w);
        if (accepted) begin
          m_hold = w;
          m_full = 1'b1;
        end
      end
      if ($urandom_range(0, 1) == 1) begin
        popRx();
        m_rxv = 1'b0;
      end
      if ($urandom_range(0, 4) == 0) begin
        clrStatus();
        m_und = 1'b0;
        m_ovf = 1'b0;
      end
      nb   = 5'($urandom_range(0, 31));
      mosi = 24'($urandom);
      len  = effLen(nb);
      exp_miso = m_full ? (m_hold & lenMask(len)) : 24'h0;
      if (!m_full) m_und = 1'b1;
      m_full = 1'b0;
      if (m_rxv) m_ovf = 1'b1;
      m_rx  = mosi & lenMask(len);
      m_rxv = 1'b1;
      applyStimulus(nb, mosi, 1'b0, 24'h0, miso, en_ok);
      checkOutput("rnd_miso", miso, exp_miso);
      checkOutput("rnd_rx_data", stream_bus.rx_data, m_rx);
      checkOutput("rnd_rx_valid", 24'(stream_bus.rx_valid), 24'(m_rxv));
      checkOutput("rnd_tx_ready", 24'(stream_bus.tx_ready), 24'(!m_full));
      checkOutput("rnd_underrun", 24'(tx_underrun), 24'(m_und));
      checkOutput("rnd_overflow", 24'(rx_overflow), 24'(m_ovf));
      checkOutput("rnd_sdo_en", 24'(en_ok), 24'h1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
